clearable_array: RTL and testbench

CLEARABLE_ARRAY -- requirements
Module: clearable_array

---
 rtl/clearable_array_pkg.sv | 10 +
 rtl/clearable_array_clear_sequencer.sv | 60 ++++++
 rtl/clearable_array.sv | 79 +++++++
 tb/tb_clearable_array.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/clearable_array_pkg.sv
// Shared types for the clearable array: sequencer state encoding.
// Used by clear_sequencer and clearable_array.
package clearable_array_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/clearable_array_clear_sequencer.sv
// Clear sweep sequencer: owns the IDLE/CLEAR FSM and the sweep counter.
// Emits busy plus a zeroing write enable/address for the storage.
module clear_sequencer
  import clearable_array_pkg::*;
#(
  parameter int index = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_req,
  output logic             busy,
  output logic             clr_we,
  output logic [index-1:0] clr_addr
);

  state_e           state_q;
  state_e           state_d;
  logic [index-1:0] cnt_q;
  logic [index-1:0] cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        // Last entry cleared: stop instead of wrapping
        if (cnt_q == '1) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Reset counts as a sweep in progress but never writes
  assign busy     = rst | (state_q == CLEAR);
  assign clr_we   = ~rst & (state_q == CLEAR);
  assign clr_addr = cnt_q;

endmodule

// File: rtl/clearable_array.sv
// Bit-maskable register array with a self-timed zeroing sweep.
// Define CLEARABLE_ARRAY_BYPASS_EN to forward same-cycle writes to dataout.
module clearable_array
  import clearable_array_pkg::*;
#(
  parameter int width = 1,
  parameter int index = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [index-1:0] rindex,
  input  logic [index-1:0] windex,
  input  logic [width-1:0] datain,
  input  logic [width-1:0] wmask,
  input  logic             flush_req,
  output logic [width-1:0] dataout,
  output logic             busy
);

  localparam int DEPTH = 1 << index;

  logic [width-1:0] mem_q [DEPTH];

  logic             clr_we;
  logic [index-1:0] clr_addr;

  logic             wr_en;
  logic [index-1:0] wr_addr;
  logic [width-1:0] wr_data;
  logic [width-1:0] merged;
  logic             user_we;
  logic [width-1:0] rd_data;

  clear_sequencer #(
    .index (index)
  ) u_seq (
    .clk       (clk),
    .rst       (rst),
    .flush_req (flush_req),
    .busy      (busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  assign merged  = (mem_q[windex] & ~wmask)
                 | (datain & wmask);
  assign user_we = load & ~busy;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = windex;
    wr_data = merged;
    if (clr_we) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_data = '0;
    end else if (user_we) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = mem_q[rindex];
`ifdef CLEARABLE_ARRAY_BYPASS_EN
    if (user_we && (rindex == windex)) begin
      rd_data = merged;
    end
`endif
    dataout = busy ? '0 : rd_data;
  end

endmodule

// File: tb/tb_clearable_array.sv
// Scoreboard bench for clearable_array (width=8, index=3).
// Stimulus queues per-cycle expectations; a negedge monitor checks them.
module tb_clearable_array;

  localparam bit BYP =
`ifdef CLEARABLE_ARRAY_BYPASS_EN
    1'b1;
`else
    1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [2:0] rindex;
  logic [2:0] windex;
  logic [7:0] datain;
  logic [7:0] wmask;
  logic       flush_req;
  logic [7:0] dataout;
  logic       busy;

  typedef struct {
    bit         chk;
    logic       busy;
    logic [7:0] data;
    string      name;
  } exp_t;

  exp_t q[$];
  bit   run = 1'b0;
  int   ncmp = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  clearable_array #(
    .width (8),
    .index (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .rindex    (rindex),
    .windex    (windex),
    .datain    (datain),
    .wmask     (wmask),
    .flush_req (flush_req),
    .dataout   (dataout),
    .busy      (busy)
  );

  always @(negedge clk) begin
    if (run) begin
      if (q.size() == 0) begin
        ncmp++;
        nfail++;
        $display("FAIL underflow: no expectation queued");
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.chk) begin
          ncmp++;
          if (busy !== e.busy || dataout !== e.data) begin
            nfail++;
            $display("FAIL %s: got busy=%b data=%h want busy=%b data=%h",
                     e.name, busy, dataout, e.busy, e.data);
          end
        end
      end
    end
  end

  task automatic cyc(input bit chk, input logic eb,
                     input logic [7:0] ed, input string nm);
    exp_t e;
    e.chk  = chk;
    e.busy = eb;
    e.data = ed;
    e.name = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] v);
    load   = 1'b1;
    datain = v;
    wmask  = 8'hFF;
    rindex = 3'd0;
    for (int i = 0; i < 8; i++) begin
      windex = i[2:0];
      cyc(1'b0, 1'b0, 8'h00, "fill");
    end
    load = 1'b0;
  endtask

  task automatic read_all(input logic [7:0] v, input string nm);
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rindex = i[2:0];
      cyc(1'b1, 1'b0, v, nm);
    end
  endtask

  initial begin
    rst       = 1'b1;
    load      = 1'b0;
    rindex    = 3'd0;
    windex    = 3'd0;
    datain    = 8'h00;
    wmask     = 8'h00;
    flush_req = 1'b0;
    @(posedge clk);
    #1;
    run = 1'b1;

    // reset pulse then boot sweep
    cyc(1'b1, 1'b1, 8'h00, "rst_busy");
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rindex = i[2:0];
      cyc(1'b1, 1'b1, 8'h00, "boot_sweep");
    end
    read_all(8'h00, "boot_zero");

    // masked writes to entry 2
    rindex = 3'd2;
    windex = 3'd2;
    load   = 1'b1;
    datain = 8'hFF;
    wmask  = 8'hFF;
    cyc(1'b1, 1'b0, BYP ? 8'hFF : 8'h00, "wmask_full");
    datain = 8'h00;
    wmask  = 8'h0F;
    cyc(1'b1, 1'b0, BYP ? 8'hF0 : 8'hFF, "wmask_low");
    load = 1'b0;
    cyc(1'b1, 1'b0, 8'hF0, "wmask_read");

    // same-cycle read of a written entry
    windex = 3'd5;
    rindex = 3'd0;
    load   = 1'b1;
    datain = 8'h11;
    wmask  = 8'hFF;
    cyc(1'b1, 1'b0, 8'h00, "pre_5");
    rindex = 3'd5;
    datain = 8'h22;
    cyc(1'b1, 1'b0, BYP ? 8'h22 : 8'h11, "bypass");
    load = 1'b0;
    cyc(1'b1, 1'b0, 8'h22, "bypass_next");

    // flush with coincident write, loads during sweep
    fill(8'hA5);
    read_all(8'hA5, "fill_read");
    flush_req = 1'b1;
    load      = 1'b1;
    windex    = 3'd3;
    rindex    = 3'd3;
    datain    = 8'h5A;
    wmask     = 8'hFF;
    cyc(1'b1, 1'b0, BYP ? 8'h5A : 8'hA5, "flush_wr");
    flush_req = 1'b0;
    datain    = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      rindex = i[2:0];
      windex = 3'(7 - i);
      cyc(1'b1, 1'b1, 8'h00, "flush_busy");
    end
    read_all(8'h00, "flush_zero");

    // reset at sweep cycle 4 restarts the sweep
    fill(8'hA5);
    flush_req = 1'b1;
    cyc(1'b0, 1'b0, 8'h00, "flush2");
    flush_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 8'h00, "pre_rst_busy");
    end
    rst = 1'b1;
    cyc(1'b1, 1'b1, 8'h00, "rst_mid");
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, 8'h00, "restart_busy");
    end
    read_all(8'h00, "restart_zero");

    // second flush_req mid-sweep is ignored
    fill(8'h3C);
    flush_req = 1'b1;
    rindex    = 3'd6;
    cyc(1'b1, 1'b0, 8'h3C, "flush3");
    flush_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      flush_req = (i == 3);
      cyc(1'b1, 1'b1, 8'h00, "reflush_busy");
    end
    flush_req = 1'b0;
    read_all(8'h00, "reflush_zero");

    run = 1'b0;
    ncmp++;
    if (q.size() != 0) begin
      nfail++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
